// File: rtl/wait_mem_if.sv
// Request/response bus of the wait-state memory.
// The master drives requests and the slave returns status and read data.
interface wait_mem_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 9
);
    localparam int unsigned ACC_W = 16;

    logic              CS;
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] Addr;
    logic [WIDTH-1:0]  Data_in;
    logic [WIDTH-1:0]  Data_out;
    logic              Ready;
    logic              Busy;
    logic              Err;
    logic [ACC_W-1:0]  Acc_cnt;

    modport master (
        output CS, Read, Write, Addr, Data_in,
        input  Data_out, Ready, Busy, Err, Acc_cnt
    );

    modport slave (
        input  CS, Read, Write, Addr, Data_in,
        output Data_out, Ready, Busy, Err, Acc_cnt
    );
endinterface

// File: rtl/wait_mem.sv
// Single-port memory with a fixed number of wait states per access,
// range and write-protect checking, and a saturating completion counter.
module wait_mem #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned WP_LIMIT = 0
) (
    input  logic     clk,
    input  logic     reset,
    wait_mem_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic              r_is_wr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_dout;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic [ACC_W-1:0]  r_acc_cnt;

    logic w_req;
    logic w_conflict;
    logic w_oob;
    logic w_wp_addr;
    logic w_wp;
    logic w_accept;
    logic w_err_nxt;
    logic w_do_access;

    assign w_req      = bus.CS & (bus.Read ^ bus.Write);
    assign w_conflict = bus.CS & bus.Read & bus.Write;
    assign w_wp       = bus.Write & w_wp_addr;

    // Range and protection checks only exist when they can ever fire
    generate
        if (DEPTH < (2 ** ADDR_W)) begin : g_oob
            assign w_oob = (32'(bus.Addr) >= DEPTH);
        end else begin : g_no_oob
            assign w_oob = 1'b0;
        end
        if (WP_LIMIT > 0) begin : g_wp
            assign w_wp_addr = (32'(bus.Addr) < WP_LIMIT);
        end else begin : g_no_wp
            assign w_wp_addr = 1'b0;
        end
    endgenerate

    // Next-state: requests are only sampled in IDLE or RESP
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_err_nxt   = 1'b0;
        w_do_access = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (w_conflict || (w_req && (w_oob || w_wp))) begin
                    w_err_nxt = 1'b1;
                end else if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CNT_W'(LATENCY);
                end
            end
            ST_BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_do_access = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_is_wr   <= 1'b0;
            r_dout    <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_acc_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == ST_RESP);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_addr  <= bus.Addr;
                r_wdata <= bus.Data_in;
                r_is_wr <= bus.Write;
            end
            if (w_do_access && !r_is_wr) begin
                r_dout <= r_mem[IDX_W'(r_addr)];
            end
            if (w_do_access && (r_acc_cnt != {ACC_W{1'b1}})) begin
                r_acc_cnt <= r_acc_cnt + ACC_W'(1);
            end
        end
    end

    // Storage survives reset; a reset before the access edge drops the write
    always_ff @(posedge clk) begin
        if (w_do_access && r_is_wr) begin
            r_mem[IDX_W'(r_addr)] <= r_wdata;
        end
    end

    assign bus.Data_out = r_dout;
    assign bus.Ready    = r_ready;
    assign bus.Busy     = r_busy;
    assign bus.Err      = r_err;
    assign bus.Acc_cnt  = r_acc_cnt;
endmodule

// File: tb/tb_wait_mem.sv
// Scoreboard bench for wait_mem: dut_a (LATENCY 2, DEPTH 256, WP_LIMIT 16)
// and dut_b (LATENCY 0, default geometry) share clock and reset.
module tb_wait_mem;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wait_mem_if #(.WIDTH(16), .ADDR_W(9)) ifa ();
    wait_mem_if #(.WIDTH(16), .ADDR_W(9)) ifb ();

    wait_mem #(.WIDTH(16), .DEPTH(256), .ADDR_W(9), .LATENCY(2), .WP_LIMIT(16))
        u_dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    wait_mem #(.WIDTH(16), .DEPTH(512), .ADDR_W(9), .LATENCY(0), .WP_LIMIT(0))
        u_dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          acc_a = 0;
    int          acc_b = 0;
    logic [15:0] last_a = '0;
    logic [15:0] mdl_a [int];

    function automatic bit get_rdy(input bit sel);
        return sel ? ifb.Ready : ifa.Ready;
    endfunction
    function automatic bit get_err(input bit sel);
        return sel ? ifb.Err : ifa.Err;
    endfunction
    function automatic bit get_busy(input bit sel);
        return sel ? ifb.Busy : ifa.Busy;
    endfunction
    function automatic logic [15:0] get_dout(input bit sel);
        return sel ? ifb.Data_out : ifa.Data_out;
    endfunction
    function automatic logic [15:0] get_acc(input bit sel);
        return sel ? ifb.Acc_cnt : ifa.Acc_cnt;
    endfunction

    task automatic drive(input bit sel, input bit cs, input bit rd, input bit wr,
                         input logic [8:0] a, input logic [15:0] d);
        if (sel) begin
            ifb.CS = cs; ifb.Read = rd; ifb.Write = wr; ifb.Addr = a; ifb.Data_in = d;
        end else begin
            ifa.CS = cs; ifa.Read = rd; ifa.Write = wr; ifa.Addr = a; ifa.Data_in = d;
        end
    endtask

    // One-cycle request; afterwards the inputs are scrambled to prove latching
    task automatic issue(input bit sel, input bit rd, input bit wr, input logic [8:0] a,
                         input logic [15:0] d, input bit is_err, input bit chk,
                         input logic [15:0] exp_d, input int lat);
        exp_t e;
        e.is_err = is_err; e.chk_data = chk; e.data = exp_d; e.lat = lat;
        sb_q.push_back(e);
        @(negedge clk);
        drive(sel, 1'b1, rd, wr, a, d);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 1'b0, ~a, ~d);
    endtask

    // Waits (bounded) for Ready or Err; lat = rising edges after acceptance
    task automatic collect(input bit sel, output exp_t e, output bit rdy, output bit err,
                           output int lat, output logic [15:0] dout);
        rdy = 1'b0; err = 1'b0; lat = -1; dout = get_dout(sel);
        for (int c = 0; c < 40; c++) begin
            if (get_rdy(sel) || get_err(sel)) begin
                rdy = get_rdy(sel); err = get_err(sel); lat = c; dout = get_dout(sel);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e.is_err = 1'b0; e.chk_data = 1'b0; e.data = '0; e.lat = -99;
        end
    endtask

    task automatic test_reset;
        logic [35:0] got;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            got = {get_rdy(s[0]), get_busy(s[0]), get_err(s[0]), get_dout(s[0]), get_acc(s[0])};
            n_cmp++;
            if (got !== 36'd0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: outputs=%h required 0", s, got);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_write_read;
        exp_t e; bit rdy, err; int lat; logic [15:0] dout, exp_d;
        bit          wr_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [8:0]  ad_t [4] = '{9'h010, 9'h010, 9'h0FF, 9'h0FF};
        logic [15:0] dt_t [4] = '{16'hA5A5, 16'h0000, 16'h1357, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            if (wr_t[i]) begin
                exp_d = last_a;
                mdl_a[int'(ad_t[i])] = dt_t[i];
            end else begin
                exp_d  = mdl_a[int'(ad_t[i])];
                last_a = exp_d;
            end
            issue(1'b0, !wr_t[i], wr_t[i], ad_t[i], dt_t[i], 1'b0, 1'b1, exp_d, 3);
            collect(1'b0, e, rdy, err, lat, dout);
            acc_a++;
            n_cmp++;
            if (rdy !== !e.is_err || err !== e.is_err || lat != e.lat) begin
                n_bad++;
                $display("FAIL wr_rd_resp[%0d]: ready=%0b err=%0b lat=%0d required ready=%0b err=%0b lat=%0d",
                         i, rdy, err, lat, !e.is_err, e.is_err, e.lat);
            end
            n_cmp++;
            if (dout !== e.data) begin
                n_bad++;
                $display("FAIL wr_rd_data[%0d]: Data_out=%h required %h", i, dout, e.data);
            end
            if (i == 1) begin
                n_cmp++;
                if (get_acc(1'b0) !== 16'(acc_a)) begin
                    n_bad++;
                    $display("FAIL wr_rd_acc2: Acc_cnt=%0d required %0d", get_acc(1'b0), acc_a);
                end
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (get_rdy(1'b0) !== 1'b0 || get_busy(1'b0) !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_pulse: ready=%0b busy=%0b required 0 0", get_rdy(1'b0), get_busy(1'b0));
        end
    endtask

    task automatic test_errors;
        exp_t e; bit rdy, err; int lat; logic [15:0] dout;
        bit          rd_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit          wr_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [8:0]  ad_t [4] = '{9'h010, 9'h1FF, 9'h100, 9'h00F};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, rd_t[i], wr_t[i], ad_t[i], 16'hDEAD, 1'b1, 1'b1, last_a, 0);
            collect(1'b0, e, rdy, err, lat, dout);
            n_cmp++;
            if (rdy !== !e.is_err || err !== e.is_err || lat != e.lat || dout !== e.data) begin
                n_bad++;
                $display("FAIL err_resp[%0d]: ready=%0b err=%0b lat=%0d dout=%h required ready=%0b err=%0b lat=%0d dout=%h",
                         i, rdy, err, lat, dout, !e.is_err, e.is_err, e.lat, e.data);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (get_err(1'b0) !== 1'b0 || get_busy(1'b0) !== 1'b0 || get_rdy(1'b0) !== 1'b0) begin
                n_bad++;
                $display("FAIL err_after[%0d]: err=%0b busy=%0b ready=%0b required 0 0 0",
                         i, get_err(1'b0), get_busy(1'b0), get_rdy(1'b0));
            end
        end
        n_cmp++;
        if (get_acc(1'b0) !== 16'(acc_a)) begin
            n_bad++;
            $display("FAIL err_acc: Acc_cnt=%0d required %0d", get_acc(1'b0), acc_a);
        end
    endtask

    task automatic test_write_protect;
        exp_t e; bit rdy, err; int lat; logic [15:0] dout, v0;
        issue(1'b0, 1'b1, 1'b0, 9'h005, 16'h0000, 1'b0, 1'b0, '0, 3);
        collect(1'b0, e, rdy, err, lat, dout);
        v0 = dout; last_a = v0; acc_a++;
        issue(1'b0, 1'b0, 1'b1, 9'h005, ~v0, 1'b1, 1'b0, '0, 0);
        collect(1'b0, e, rdy, err, lat, dout);
        n_cmp++;
        if (rdy !== 1'b0 || err !== 1'b1 || lat != e.lat) begin
            n_bad++;
            $display("FAIL wp_write: ready=%0b err=%0b lat=%0d required 0 1 %0d", rdy, err, lat, e.lat);
        end
        issue(1'b0, 1'b1, 1'b0, 9'h005, 16'h0000, 1'b0, 1'b1, v0, 3);
        collect(1'b0, e, rdy, err, lat, dout);
        acc_a++;
        n_cmp++;
        if (rdy !== 1'b1 || dout !== e.data) begin
            n_bad++;
            $display("FAIL wp_readback: ready=%0b dout=%h required 1 %h", rdy, dout, e.data);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e; bit rdy, err; int lat; logic [15:0] dout;
        logic [15:0] wd [2] = '{16'h1111, 16'h2222};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, 1'b0, 1'b1, 9'(i + 1), wd[i], 1'b0, 1'b1, 16'h0000, 1);
            collect(1'b1, e, rdy, err, lat, dout);
            acc_b++;
            n_cmp++;
            if (rdy !== 1'b1 || err !== 1'b0 || lat != e.lat || dout !== e.data) begin
                n_bad++;
                $display("FAIL b2b_write[%0d]: ready=%0b err=%0b lat=%0d dout=%h required 1 0 %0d %h",
                         i, rdy, err, lat, dout, e.lat, e.data);
            end
        end
        for (int i = 0; i < 2; i++) begin
            e.is_err = 1'b0; e.chk_data = 1'b1; e.data = wd[i]; e.lat = 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 9'h001, 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 9'h002, 16'h0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0);
                n_cmp++;
                if (get_rdy(1'b1) !== 1'b0 || get_busy(1'b1) !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_gap: ready=%0b busy=%0b required 0 1", get_rdy(1'b1), get_busy(1'b1));
                end
            end else begin
                e = sb_q.pop_front();
                acc_b++;
                n_cmp++;
                if (get_rdy(1'b1) !== 1'b1 || get_dout(1'b1) !== e.data) begin
                    n_bad++;
                    $display("FAIL b2b_read@%0d: ready=%0b dout=%h required 1 %h",
                             c, get_rdy(1'b1), get_dout(1'b1), e.data);
                end
            end
        end
        n_cmp++;
        if (get_acc(1'b1) !== 16'(acc_b)) begin
            n_bad++;
            $display("FAIL b2b_acc: Acc_cnt=%0d required %0d", get_acc(1'b1), acc_b);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e; bit rdy, err; int lat; logic [15:0] dout;
        logic [35:0] got;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h010, 16'h1234);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0);
        n_cmp++;
        if (get_busy(1'b0) !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_busy: busy=%0b required 1", get_busy(1'b0));
        end
        #2 reset = 1'b0;
        #1;
        got = {get_rdy(1'b0), get_busy(1'b0), get_err(1'b0), get_dout(1'b0), get_acc(1'b0)};
        n_cmp++;
        if (got !== 36'd0) begin
            n_bad++;
            $display("FAIL midrst_outputs: outputs=%h required 0", got);
        end
        @(negedge clk);
        reset = 1'b1;
        acc_a = 0; acc_b = 0; last_a = '0;
        issue(1'b0, 1'b1, 1'b0, 9'h010, 16'h0, 1'b0, 1'b1, mdl_a[16], 3);
        collect(1'b0, e, rdy, err, lat, dout);
        acc_a++;
        n_cmp++;
        if (rdy !== 1'b1 || lat != e.lat || dout !== e.data || get_acc(1'b0) !== 16'(acc_a)) begin
            n_bad++;
            $display("FAIL midrst_read: ready=%0b lat=%0d dout=%h acc=%0d required 1 %0d %h %0d",
                     rdy, lat, dout, get_acc(1'b0), e.lat, e.data, acc_a);
        end
    endtask

    task automatic test_saturation;
        exp_t e; bit rdy, err; int lat; logic [15:0] dout;
        logic [15:0] wd [2] = '{16'h1111, 16'h2222};
        @(negedge clk);
        force u_dut_b.r_acc_cnt = 16'hFFFE;
        @(negedge clk);
        release u_dut_b.r_acc_cnt;
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, 1'b1, 1'b0, 9'(i + 1), 16'h0, 1'b0, 1'b1, wd[i], 1);
            collect(1'b1, e, rdy, err, lat, dout);
            n_cmp++;
            if (rdy !== 1'b1 || lat != e.lat || dout !== e.data || get_acc(1'b1) !== 16'hFFFF) begin
                n_bad++;
                $display("FAIL sat[%0d]: ready=%0b lat=%0d dout=%h acc=%h required 1 %0d %h ffff",
                         i, rdy, lat, dout, get_acc(1'b1), e.lat, e.data);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0);
        test_reset();
        test_write_read();
        test_errors();
        test_write_protect();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wait_mem.md
WAIT_MEM -- requirements
Module: wait_mem

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 512, number of words.
REQ-003 Parameter ADDR_W, default 9, address width in bits.
REQ-004 Parameter LATENCY, default 2, wait states per access (0..15).
REQ-005 Parameter WP_LIMIT, default 0, addresses below this value are write-protected.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 CS  input  1  chip select; a request is present when CS=1 and exactly one of Read/Write is 1.
REQ-009 Read  input  1  read request.
REQ-010 Write  input  1  write request.
REQ-011 Addr  input  ADDR_W  word address.
REQ-012 Data_in  input  WIDTH  write data.
REQ-013 Data_out  output  WIDTH  read data, registered.
REQ-014 Ready  output  1  one-cycle completion pulse.
REQ-015 Busy  output  1  high while an accepted access is outstanding (BUSY or RESP state).
REQ-016 Err  output  1  one-cycle error pulse.
REQ-017 Acc_cnt  output  16  saturating count of successfully completed accesses.

Function
REQ-018 FSM states: IDLE, BUSY, RESP.
REQ-019 IDLE, valid request at edge E0: latch Addr, Data_in and op; load wait counter with LATENCY; go to BUSY.
REQ-020 BUSY with counter >0: decrement. BUSY with counter =0: perform access at that edge; go to RESP.
REQ-021 Ready=1 exactly during RESP; RESP lasts one cycle, so Ready rises at edge E0+LATENCY+1.
REQ-022 Read: Data_out updates at the access edge; holds until the next completed read, including across writes and errors.
REQ-023 Write: array word updates at the access edge; Data_out unchanged.
REQ-024 RESP with a valid request present: accept it back-to-back, same as IDLE; otherwise return to IDLE.
REQ-025 Inputs in BUSY are ignored; CS, Addr or Data_in changes after acceptance do not affect the latched access.
REQ-026 CS=1 with Read=Write=1, sampled in IDLE or RESP: no access; Err=1 for the next cycle; state goes to IDLE.
REQ-027 Valid request with Addr>=DEPTH: no access; Err=1 for the next cycle; no Ready; state goes to IDLE.
REQ-028 Write request with Addr<WP_LIMIT: no array change; Err=1 for the next cycle; state goes to IDLE.
REQ-029 Err and Ready are never high in the same cycle.
REQ-030 Acc_cnt increments by 1 on each Ready; it holds at 16'hFFFF.
REQ-031 CS=0, or CS=1 with Read=Write=0: no action, no Err.

Reset
REQ-032 reset=0 forces immediately: state IDLE, Ready=0, Busy=0, Err=0, Data_out=0, Acc_cnt=0, wait counter=0.
REQ-033 reset asserted mid-access aborts the access; any write not yet performed is lost.
REQ-034 Array contents are not cleared by reset.
REQ-035 reset is released synchronously to clk by the environment; the first request is accepted at the first rising edge after release.

Verification
REQ-036 LATENCY=2, write 16'hA5A5 to 9'h010, then read 9'h010 -> Ready at E0+3 for each access; Data_out=16'hA5A5; Acc_cnt=2.
REQ-037 Back-to-back reads to 9'h001 and 9'h002, CS held high, LATENCY=0 -> Ready high on two consecutive RESP cycles separated by one BUSY cycle; correct data each time.
REQ-038 Read=Write=1 with CS=1 -> Err for one cycle; no Ready; Acc_cnt unchanged.
REQ-039 DEPTH=256, Addr=9'h1FF -> Err; no Ready. WP_LIMIT=16, write to 9'h005 -> Err; a later read of 9'h005 returns the prior contents.
REQ-040 reset pulsed during BUSY of a write -> all outputs 0 at once; a later read shows the old word; Acc_cnt=0.
REQ-041 Acc_cnt preloaded by 65535 accesses, then one more access -> Acc_cnt stays 16'hFFFF.
